// File: rtl/axis_frame_modifier_p.sv
// ---------------------------------------------------------------------------
// axis_frame_modifier_p
//
// AXI4-Stream frame payload modifier. It sits between the RX FIFO interface
// and the TX FIFO interface. The leading HDR_BYTES of every frame pass
// through untouched. Every later word is combined with op_val using the
// operation selected by mode. Frames longer than MAX_WORDS beats are cut
// short: the last kept beat is marked tlast and the rest of the frame is
// discarded.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   mode              0 pass, 1 add, 2 subtract, 3 xor (sampled per frame)
//   op_val            operand for add/sub/xor (sampled per frame)
//   s_axis_*          upstream AXI4-Stream slave (tvalid/tready/tdata/tlast/tuser)
//   m_axis_*          downstream AXI4-Stream master
//   trunc_pulse       one-cycle pulse when a frame gets truncated
//   busy              high while a frame is in progress
//   frame_cnt         emitted-frame counter   (only with FRMMOD_STATS_EN)
//   trunc_cnt         truncated-frame counter (only with FRMMOD_STATS_EN)
//
// Optional feature macro: FRMMOD_STATS_EN
// ---------------------------------------------------------------------------
module axis_frame_modifier_p #(
  parameter int DATA_W    = 32,
  parameter int USER_W    = 4,
  parameter int HDR_BYTES = 16,
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] op_val,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              trunc_pulse,
`ifdef FRMMOD_STATS_EN
  output logic              busy,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       trunc_cnt
`else
  output logic              busy
`endif
);

  localparam int HDR_WORDS = HDR_BYTES / (DATA_W / 8);
  localparam int IDX_W     = $clog2(MAX_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state, state_next;
  logic [IDX_W-1:0]  word_idx, idx_next;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] op_r;

  // Two-entry output buffer
  logic [DATA_W-1:0] buf_data [2];
  logic              buf_last [2];
  logic [USER_W-1:0] buf_user [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_next;
  logic              ready_r;
  logic              trunc_r;

  logic              accept, emit, store, at_max, trunc_hit, is_hdr;
  logic [1:0]        cur_mode;
  logic [DATA_W-1:0] cur_op, mod_data;
  logic [IDX_W-1:0]  cur_idx;

  assign accept        = s_axis_tvalid & ready_r;
  assign emit          = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = ready_r;
  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = buf_data[rd_ptr];
  assign m_axis_tlast  = buf_last[rd_ptr];
  assign m_axis_tuser  = buf_user[rd_ptr];
  assign trunc_pulse   = trunc_r;
  assign busy          = (state != IDLE);

  // The first beat of a frame uses the live mode/op_val and is word 0; later
  // beats use the copies captured on that first beat.
  assign cur_mode  = (state == IDLE) ? mode   : mode_r;
  assign cur_op    = (state == IDLE) ? op_val : op_r;
  assign cur_idx   = (state == IDLE) ? '0     : word_idx;
  assign is_hdr    = int'(cur_idx) < HDR_WORDS;
  assign at_max    = (word_idx == IDX_W'(MAX_WORDS - 1));
  assign trunc_hit = accept & (state == DATA) & at_max & ~s_axis_tlast;
  assign store     = accept & (state != DROP);

  // Payload operation; add/sub wrap naturally at DATA_W bits
  always_comb begin
    mod_data = s_axis_tdata;
    if (!is_hdr) begin
      case (cur_mode)
        2'd1:    mod_data = s_axis_tdata + cur_op;
        2'd2:    mod_data = s_axis_tdata - cur_op;
        2'd3:    mod_data = s_axis_tdata ^ cur_op;
        default: mod_data = s_axis_tdata;
      endcase
    end
  end

  // Frame state and word index; the index stops at MAX_WORDS-1 because
  // reaching it without tlast moves the frame into DROP
  always_comb begin
    state_next = state;
    idx_next   = word_idx;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!s_axis_tlast) begin
            state_next = DATA;
            idx_next   = IDX_W'(1);
          end
        end
        DATA: begin
          if (s_axis_tlast) begin
            state_next = IDLE;
            idx_next   = '0;
          end else if (at_max) begin
            state_next = DROP;
          end else begin
            idx_next = word_idx + IDX_W'(1);
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            state_next = IDLE;
            idx_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (store && !emit)      count_next = count + 2'd1;
    else if (emit && !store) count_next = count - 2'd1;
  end

  // Ready is registered from the occupancy after this cycle, so a beat
  // accepted next cycle always has room; DROP swallows beats and stays ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= '0;
      mode_r   <= '0;
      op_r     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      ready_r  <= 1'b0;
      trunc_r  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
        buf_user[i] <= '0;
      end
    end else begin
      state    <= state_next;
      word_idx <= idx_next;
      count    <= count_next;
      ready_r  <= (state_next == DROP) | (count_next != 2'd2);
      trunc_r  <= trunc_hit;
      if (accept && state == IDLE) begin
        mode_r <= mode;
        op_r   <= op_val;
      end
      if (store) begin
        buf_data[wr_ptr] <= mod_data;
        buf_last[wr_ptr] <= s_axis_tlast | trunc_hit;
        buf_user[wr_ptr] <= s_axis_tuser;
        wr_ptr           <= ~wr_ptr;
      end
      if (emit) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef FRMMOD_STATS_EN
  // Free-running wrap-around statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      if (emit && m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
      if (trunc_r)              trunc_cnt <= trunc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_modifier_p.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_modifier_p
//
// Directed and randomised-backpressure bench for axis_frame_modifier_p with
// MAX_WORDS=8 and a 4-word header. A queue of expected output beats is built
// as frames are driven; the output side pops and compares every emitted beat.
// ---------------------------------------------------------------------------
module tb_axis_frame_modifier_p;

  localparam int DATA_W    = 32;
  localparam int USER_W    = 4;
  localparam int HDR_BYTES = 16;
  localparam int MAX_WORDS = 8;
  localparam int HDR_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = '0;
  logic [DATA_W-1:0] op_val = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic [USER_W-1:0] s_axis_tuser = '0;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic [USER_W-1:0] m_axis_tuser;
  logic              trunc_pulse;
  logic              busy;
`ifdef FRMMOD_STATS_EN
  logic [31:0]       frame_cnt;
  logic [15:0]       trunc_cnt;
`endif

  axis_frame_modifier_p #(
    .DATA_W(DATA_W), .USER_W(USER_W), .HDR_BYTES(HDR_BYTES), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .op_val(op_val),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .trunc_pulse(trunc_pulse),
`ifdef FRMMOD_STATS_EN
    .busy(busy), .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [USER_W-1:0] user;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t       expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          truncSeen = 0;
  int          truncExpected = 0;
  bit          randReady = 1'b0;
  bit          fixedReady = 1'b1;
  logic [31:0] txData [16];

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [1:0] md, input logic [31:0] ov,
                                            input int idx, input logic [31:0] d);
    if (idx < HDR_WORDS) return d;
    case (md)
      2'd1:    return d + ov;
      2'd2:    return d - ov;
      2'd3:    return d ^ ov;
      default: return d;
    endcase
  endfunction

  // Output side: set m_tready for the coming edge, then check the beat that
  // edge will transfer, stall stability and truncation pulses
  initial begin
    bit    stalled = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t exp;
    forever begin
      @(negedge clk);
      m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : fixedReady;
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) checkOutput("stall_stable", {m_axis_tvalid, 27'd0, cur}, {1'b1, 27'd0, held});
        if (trunc_pulse) truncSeen++;
        if (m_axis_tvalid && m_axis_tready) begin
          if (expQ.size() == 0) begin
            checkOutput("extra_beat", 64'(cur), 64'd0);
          end else begin
            exp = expQ.pop_front();
            checkOutput("out_beat", 64'(cur), 64'(exp));
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = cur;
      end
    end
  end

  // Present one beat from a negedge and return at the negedge after it is taken
  task automatic applyStimulus(input logic [31:0] d, input logic l, input logic [3:0] u);
    int guard = 0;
    bit done  = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    while (!done) begin
      if (s_axis_tready) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!done) begin
        guard++;
        if (guard > 200) begin
          checkOutput("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  // Drive a frame from txData; after the first beat mode/op_val are scrambled
  // (mode forced to altMode) to prove they are only sampled once per frame
  task automatic sendFrame(input int len, input logic [1:0] md, input logic [31:0] ov,
                           input logic [1:0] altMode, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        mode   = md;
        op_val = ov;
      end else begin
        mode   = altMode;
        op_val = $urandom;
      end
      if (i < MAX_WORDS)
        expQ.push_back({4'(i), (i == len - 1) || (i == MAX_WORDS - 1), modelWord(md, ov, i, txData[i])});
      applyStimulus(txData[i], i == len - 1, 4'(i));
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
    end
    if (len > MAX_WORDS) truncExpected++;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_trunc", 64'(trunc_pulse), 64'd0);
    checkOutput("rst_m_data", {m_axis_tdata, 31'd0, m_axis_tlast}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(s_axis_tready), 64'd1);

    // Test 1: add 1 over data 0..7, latency and busy
    for (int i = 0; i < 16; i++) txData[i] = 32'(i);
    fixedReady = 1'b1;
    mode = 2'd1; op_val = 32'd1;
    expQ.push_back({4'd0, 1'b0, 32'd0});
    applyStimulus(32'd0, 1'b0, 4'd0);
    checkOutput("latency_valid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("latency_data", 64'(m_axis_tdata), 64'd0);
    checkOutput("busy_mid_frame", 64'(busy), 64'd1);
    for (int i = 1; i < 8; i++) begin
      mode = 2'd2; op_val = 32'h55;
      expQ.push_back({4'(i), i == 7, (i < 4) ? 32'(i) : 32'(i + 1)});
      applyStimulus(32'(i), i == 7, 4'(i));
    end
    s_axis_tvalid = 1'b0;
    waitDrain();
    checkOutput("busy_idle", 64'(busy), 64'd0);

    // Test 2: xor and add wrap-around
    txData[4] = 32'h0000FFFF;
    expQ.push_back({4'd0, 1'b0, 32'd0});
    expQ.push_back({4'd1, 1'b0, 32'd1});
    expQ.push_back({4'd2, 1'b0, 32'd2});
    expQ.push_back({4'd3, 1'b0, 32'd3});
    expQ.push_back({4'd4, 1'b1, 32'hFFFF0000});
    mode = 2'd3; op_val = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(txData[i], i == 4, 4'(i));
      mode = 2'd0;
    end
    s_axis_tvalid = 1'b0;
    txData[4] = 32'hFFFFFFFF;
    expQ.push_back({4'd0, 1'b0, 32'd0});
    expQ.push_back({4'd1, 1'b0, 32'd1});
    expQ.push_back({4'd2, 1'b0, 32'd2});
    expQ.push_back({4'd3, 1'b0, 32'd3});
    expQ.push_back({4'd4, 1'b1, 32'h00000000});
    mode = 2'd1; op_val = 32'd1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(txData[i], i == 4, 4'(i));
      mode = 2'd3;
    end
    s_axis_tvalid = 1'b0;
    waitDrain();

    // Test 3: random backpressure over 20 frames
    randReady = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) txData[i] = $urandom;
      sendFrame($urandom_range(1, MAX_WORDS), 2'($urandom_range(0, 3)), $urandom,
                2'($urandom_range(0, 3)), 1'b1);
    end
    waitDrain();
    randReady = 1'b0;
    fixedReady = 1'b1;
    repeat (2) @(negedge clk);

    // Test 4: 12-beat frame truncated to 8, then an intact frame
    for (int i = 0; i < 16; i++) txData[i] = 32'(i);
    sendFrame(12, 2'd1, 32'd1, 2'd0, 1'b0);
    waitDrain();
    checkOutput("trunc_once", 64'(truncSeen), 64'd1);
    checkOutput("busy_after_drop", 64'(busy), 64'd0);
    sendFrame(6, 2'd3, 32'hA5A5A5A5, 2'd1, 1'b0);
    waitDrain();

    // Test 5: mode change mid-frame is ignored; next frame subtracts
    for (int i = 0; i < 16; i++) txData[i] = 32'(i);
    sendFrame(6, 2'd1, 32'd1, 2'd2, 1'b0);
    sendFrame(6, 2'd2, 32'd1, 2'd1, 1'b0);
    waitDrain();

    // Test 6: reset mid-frame with beats parked in the output buffer
    fixedReady = 1'b0;
    @(negedge clk);
    mode = 2'd1; op_val = 32'd9;
    applyStimulus(32'h11, 1'b0, 4'd0);
    applyStimulus(32'h22, 1'b0, 4'd1);
    s_axis_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("midrst_m_data", {m_axis_tdata, 27'd0, m_axis_tuser, m_axis_tlast}, 64'd0);
    expQ.delete();
    rst_n = 1'b1;
    fixedReady = 1'b1;
    @(negedge clk);
    mode = 2'd1; op_val = 32'd5;
    expQ.push_back({4'd3, 1'b1, 32'h1234});
    applyStimulus(32'h1234, 1'b1, 4'd3);
    s_axis_tvalid = 1'b0;
    waitDrain();
`ifdef FRMMOD_STATS_EN
    checkOutput("frame_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("trunc_cnt", 64'(trunc_cnt), 64'd0);
`endif
    checkOutput("trunc_total", 64'(truncSeen), 64'(truncExpected));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
